// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Index width needed to address n registers.
    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

    // Register index for the default 32-entry configuration.
    typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Bundle of the issue, writeback and operand-read signals of the register file.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
) ();
    localparam int AW = addr_w(NREGS);

    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic [NREGS-1:0]    busy_vec;

    // Decode/issue and writeback side.
    modport master (
        output we, waddr, wdata, raddr, issue_valid, issue_rd,
        input  rdata, rbusy, busy_vec
    );

    // Register file side.
    modport slave (
        input  we, waddr, wdata, raddr, issue_valid, issue_rd,
        output rdata, rbusy, busy_vec
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set when a producer issues, cleared when it writes back.
// A new issue to the same register wins over a retiring write in the same cycle.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter int AW       = addr_w(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_valid_i,
    input  logic [AW-1:0]    set_idx_i,
    input  logic             clr_valid_i,
    input  logic [AW-1:0]    clr_idx_i,
    output logic [NREGS-1:0] busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy state with set-over-clear priority; register 0 never goes busy.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (set_valid_i && (set_idx_i == AW'(r)) && !(ZERO_REG && (r == 0))) begin
                busy_d[r] = 1'b1;
            end else if (clr_valid_i && (clr_idx_i == AW'(r))) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
    end

    // Busy vector state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= {NREGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: NRD combinational read ports, one write port,
// optional writeback bypass, hardwired x0 and an in-flight write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);

    localparam int AW = addr_w(NREGS);

    logic [XLEN-1:0]     regs_q [NREGS];
    logic                we_eff_s;
    logic [NREGS-1:0]    busy_s;
    logic [NRD*XLEN-1:0] rdata_s;
    logic [NRD-1:0]      rbusy_s;

    // A write to x0 is dropped entirely when x0 is hardwired.
    always_comb begin
        we_eff_s = bus.we && !(ZERO_REG && (bus.waddr == {AW{1'b0}}));
    end

    // Architectural storage; the write lands on the edge after writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= {XLEN{1'b0}};
            end
        end else if (we_eff_s) begin
            regs_q[bus.waddr] <= bus.wdata;
        end
    end

    reg_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_valid_i (bus.issue_valid),
        .set_idx_i   (bus.issue_rd),
        .clr_valid_i (we_eff_s),
        .clr_idx_i   (bus.waddr),
        .busy_o      (busy_s)
    );

    // Operand read muxes: x0, then bypassed writeback data, then storage.
    // Outputs are forced low while reset is held so bypass cannot leak through.
    always_comb begin
        rdata_s = {(NRD*XLEN){1'b0}};
        rbusy_s = {NRD{1'b0}};
        for (int p = 0; p < NRD; p++) begin
            if (!rst_n) begin
                rdata_s[p*XLEN +: XLEN] = {XLEN{1'b0}};
                rbusy_s[p]              = 1'b0;
            end else if (ZERO_REG && (bus.raddr[p*AW +: AW] == {AW{1'b0}})) begin
                rdata_s[p*XLEN +: XLEN] = {XLEN{1'b0}};
                rbusy_s[p]              = 1'b0;
            end else if (BYPASS && we_eff_s && (bus.waddr == bus.raddr[p*AW +: AW])) begin
                rdata_s[p*XLEN +: XLEN] = bus.wdata;
                rbusy_s[p]              = 1'b0;
            end else begin
                rdata_s[p*XLEN +: XLEN] = regs_q[bus.raddr[p*AW +: AW]];
                rbusy_s[p]              = busy_s[bus.raddr[p*AW +: AW]];
            end
        end
    end

    assign bus.rdata    = rdata_s;
    assign bus.rbusy    = rbusy_s;
    assign bus.busy_vec = busy_s;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default config with and without bypass sharing one
// stimulus stream, plus a 16x64, 3-port config; all checked against a model.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    // Stimulus for the two 32x32 instances (A: bypass, B: no bypass).
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic        issue_valid;
    logic [4:0]  issue_rd;

    // Stimulus for the 16x64, 3-port instance C.
    logic        we_c;
    logic [3:0]  waddr_c;
    logic [63:0] wdata_c;
    logic [11:0] raddr_c;
    logic        iv_c;
    logic [3:0]  ird_c;

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifa ();
    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifb ();
    regfile_sb_if #(.XLEN(64), .NREGS(16), .NRD(3)) ifc ();

    assign ifa.we = we;   assign ifa.waddr = waddr; assign ifa.wdata = wdata;
    assign ifa.raddr = raddr; assign ifa.issue_valid = issue_valid; assign ifa.issue_rd = issue_rd;
    assign ifb.we = we;   assign ifb.waddr = waddr; assign ifb.wdata = wdata;
    assign ifb.raddr = raddr; assign ifb.issue_valid = issue_valid; assign ifb.issue_rd = issue_rd;
    assign ifc.we = we_c; assign ifc.waddr = waddr_c; assign ifc.wdata = wdata_c;
    assign ifc.raddr = raddr_c; assign ifc.issue_valid = iv_c; assign ifc.issue_rd = ird_c;

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic [63:0] mc_regs [16];
    logic [15:0] mc_busy;

    // Architectural state: commit writes, retire then (re)issue busy bits.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
            for (int i = 0; i < 16; i++) mc_regs[i] <= 64'h0;
            m_busy  <= 32'h0;
            mc_busy <= 16'h0;
        end else begin
            if (we && waddr != 5'd0) begin
                m_regs[waddr] <= wdata;
                m_busy[waddr] <= 1'b0;
            end
            if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] <= 1'b1;
            if (we_c && waddr_c != 4'd0) begin
                mc_regs[waddr_c] <= wdata_c;
                mc_busy[waddr_c] <= 1'b0;
            end
            if (iv_c && ird_c != 4'd0) mc_busy[ird_c] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'h0;
        if (byp && we && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input bit byp, input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 1'b0;
        return m_busy[a] && !(byp && we && waddr == a);
    endfunction

    function automatic logic [63:0] exp_rd_c(input logic [3:0] a);
        if (!rst_n || a == 4'd0) return 64'h0;
        if (we_c && waddr_c == a) return wdata_c;
        return mc_regs[a];
    endfunction

    function automatic logic exp_busy_c(input logic [3:0] a);
        if (!rst_n || a == 4'd0) return 1'b0;
        return mc_busy[a] && !(we_c && waddr_c == a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison of all ports of all instances against the model.
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            check("A_rdata", 64'(ifa.rdata[p*32 +: 32]), 64'(exp_rd(1'b1, raddr[p*5 +: 5])));
            check("A_rbusy", 64'(ifa.rbusy[p]),          64'(exp_busy(1'b1, raddr[p*5 +: 5])));
            check("B_rdata", 64'(ifb.rdata[p*32 +: 32]), 64'(exp_rd(1'b0, raddr[p*5 +: 5])));
            check("B_rbusy", 64'(ifb.rbusy[p]),          64'(exp_busy(1'b0, raddr[p*5 +: 5])));
        end
        check("A_busy_vec", 64'(ifa.busy_vec), 64'(rst_n ? m_busy : 32'h0));
        check("B_busy_vec", 64'(ifb.busy_vec), 64'(rst_n ? m_busy : 32'h0));
        for (int p = 0; p < 3; p++) begin
            check("C_rdata", ifc.rdata[p*64 +: 64],  exp_rd_c(raddr_c[p*4 +: 4]));
            check("C_rbusy", 64'(ifc.rbusy[p]),      64'(exp_busy_c(raddr_c[p*4 +: 4])));
        end
        check("C_busy_vec", 64'(ifc.busy_vec), 64'(rst_n ? mc_busy : 16'h0));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; waddr = 5'd0; wdata = 32'h0; issue_valid = 1'b0; issue_rd = 5'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        raddr = 10'd0;
        we_c = 1'b0; waddr_c = 4'd0; wdata_c = 64'h0; raddr_c = 12'd0; iv_c = 1'b0; ird_c = 4'd0;

        // Reset held for two cycles, with a write presented that must not land.
        we = 1'b1; waddr = 5'd5; wdata = 32'hFFFF_FFFF; raddr = {5'd5, 5'd5};
        step();
        #1 check("L_rst_rdata", 64'(ifa.rdata), 64'h0);
        check("L_rst_busy_vec", 64'(ifa.busy_vec), 64'h0);
        step();
        idle();
        rst_n = 1'b1;

        // x0 ignores writes; x5 commits one cycle later.
        we = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF;
        step();
        waddr = 5'd5; wdata = 32'h1234_5678;
        step();
        idle();
        raddr = {5'd5, 5'd0};
        #1 check("L_x0_read", 64'(ifa.rdata[31:0]), 64'h0);
        check("L_x5_read", 64'(ifa.rdata[63:32]), 64'h1234_5678);
        check("L_busy_zero", 64'(ifa.busy_vec), 64'h0);

        // Same-cycle bypass on port 1; no-bypass instance shows old value.
        step();
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; raddr = {5'd7, 5'd0};
        #1 check("L_bypass_A", 64'(ifa.rdata[63:32]), 64'hA5A5_A5A5);
        check("L_nobypass_B", 64'(ifb.rdata[63:32]), 64'h0);
        step();
        idle();
        #1 check("L_nobypass_B_next", 64'(ifb.rdata[63:32]), 64'hA5A5_A5A5);

        // Scoreboard: issue x3, observe busy, then writeback clears it.
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        idle();
        raddr = {5'd0, 5'd3};
        #1 check("L_x3_busy", 64'(ifa.rbusy[0]), 64'h1);
        step();
        #1 check("L_x3_busy_hold", 64'(ifa.rbusy[0]), 64'h1);
        we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0033;
        #1 check("L_x3_bypass_notbusy", 64'(ifa.rbusy[0]), 64'h0);
        check("L_x3_nobypass_busy", 64'(ifb.rbusy[0]), 64'h1);
        check("L_x3_bypass_data", 64'(ifa.rdata[31:0]), 64'h33);
        step();
        idle();
        #1 check("L_x3_cleared", 64'(ifa.busy_vec[3]), 64'h0);

        // Set beats clear when issue and writeback hit x9 together.
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0099;
        step();
        idle();
        raddr = {5'd0, 5'd9};
        #1 check("L_prio_busy", 64'(ifa.busy_vec[9]), 64'h1);
        check("L_prio_data", 64'(ifb.rdata[31:0]), 64'h99);
        check("L_prio_rbusy", 64'(ifa.rbusy[0]), 64'h1);

        // Asynchronous reset mid-cycle with x4 busy and holding 0x55.
        we = 1'b1; waddr = 5'd4; wdata = 32'h0000_0055; issue_valid = 1'b1; issue_rd = 5'd4;
        step();
        idle();
        raddr = {5'd0, 5'd4};
        #1 check("L_x4_pre", 64'(ifa.rdata[31:0]), 64'h55);
        check("L_x4_pre_busy", 64'(ifa.rbusy[0]), 64'h1);
        we = 1'b1; waddr = 5'd4; wdata = 32'h0000_0077;
        #1 rst_n = 1'b0;
        #1 check("L_arst_rdata", 64'(ifa.rdata[31:0]), 64'h0);
        check("L_arst_rbusy", 64'(ifa.rbusy[0]), 64'h0);
        check("L_arst_busy_vec", 64'(ifa.busy_vec), 64'h0);
        step();
        idle();
        rst_n = 1'b1;
        #1 check("L_after_rst_x4", 64'(ifb.rdata[31:0]), 64'h0);

        // Wide configuration: port 2 bypass, port 1 on x0, then committed value.
        step();
        we_c = 1'b1; waddr_c = 4'd2; wdata_c = 64'h0123_4567_89AB_CDEF; raddr_c = {4'd2, 4'd0, 4'd2};
        #1 check("L_C_bypass_p2", ifc.rdata[191:128], 64'h0123_4567_89AB_CDEF);
        check("L_C_x0_p1", ifc.rdata[127:64], 64'h0);
        step();
        we_c = 1'b0;
        #1 check("L_C_commit_p0", ifc.rdata[63:0], 64'h0123_4567_89AB_CDEF);

        // Randomised issue/writeback traffic on small index ranges to force hazards.
        for (int i = 0; i < 400; i++) begin
            step();
            we          = 1'($urandom_range(0, 1));
            waddr       = 5'($urandom_range(0, 7));
            wdata       = $urandom;
            raddr       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom_range(0, 7));
            we_c        = 1'($urandom_range(0, 1));
            waddr_c     = 4'($urandom_range(0, 7));
            wdata_c     = {$urandom, $urandom};
            raddr_c     = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            iv_c        = ($urandom_range(0, 2) == 0);
            ird_c       = 4'($urandom_range(0, 7));
            if (i == 200) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        step();
        idle();
        we_c = 1'b0; iv_c = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file with multiple combinational read ports, one write port, optional write-to-read bypass, and a hardwired-zero register.
An integrated per-register busy scoreboard tracks in-flight writes: set at issue, cleared at writeback.
Sits between decode/issue, which reads operands and checks hazards, and writeback, which commits results.
Replaces the single-generation fixed 32x32 two-read-port register file.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >= 2)
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, register 0 reads as 0, ignores writes, never goes busy
BYPASS, 1, same-cycle writeback data forwarded to read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
we  in  1  writeback valid
waddr  in  AW  writeback register index (AW = $clog2(NREGS))
wdata  in  XLEN  writeback data
raddr  in  NRD*AW  read indices, port i at bits [i*AW +: AW]
rdata  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN]
rbusy  out  NRD  port i operand has a pending write not yet committed
issue_valid  in  1  instruction issued with a destination register
issue_rd  in  AW  destination of the issuing instruction
busy_vec  out  NREGS  raw scoreboard state, for debug/verification

Behaviour:
- Reset (rst_n=0, asynchronous): all registers = 0; all busy bits = 0. While held low, rdata = 0, rbusy = 0, busy_vec = 0. Reset mid-stream discards all pending state; no write is committed on the edge where rst_n deasserts.
- Effective write: we_eff = we && !(ZERO_REG && waddr==0). On a rising edge with we_eff, regs[waddr] <= wdata. Write latency is 1 cycle.
- Reads are combinational, with 0-cycle latency from raddr:
  - if ZERO_REG and raddr[i]==0, rdata[i] = 0;
  - else if BYPASS and we_eff and waddr==raddr[i], rdata[i] = wdata;
  - else rdata[i] = regs[raddr[i]].
  - With BYPASS=0, a read of the register being written returns the old value; the new value appears the next cycle.
- Scoreboard, per register r, at a rising edge:
  - set = issue_valid && issue_rd==r && !(ZERO_REG && r==0)
  - clr = we_eff && waddr==r
  - busy[r] <= set ? 1 : (clr ? 0 : busy[r]). Set has priority over clear: a new producer supersedes the retiring one.
- Writes with busy[waddr]=0 are legal: the value commits and busy stays 0.
- rbusy[i] = busy[raddr[i]] && !(BYPASS && we_eff && waddr==raddr[i]). A bypassed operand is not busy. rbusy[i] = 0 for register 0 when ZERO_REG.
- busy_vec = busy, registered, with no bypass applied.
- All read ports are independent. Several ports reading the same index return identical data and busy.
- Out-of-range indices cannot occur because NREGS is a power of 2.

Decomposition:
- Package regfile_pkg:
  - XLEN_DEF and NREGS_DEF constants;
  - function addr_w(n) returning $clog2(n);
  - typedef reg_idx_t, logic [4:0] for the default configuration.
- Sub-module reg_scoreboard(NREGS, ZERO_REG) holds the busy vector and implements the set/clear priority.
- regfile_sb instantiates reg_scoreboard and contains the storage, the read muxes and the bypass logic.

Test Plan:
- Reset and zero register: hold rst_n=0 for 2 cycles, then write x0=0xDEADBEEF and x5=0x12345678; read raddr={0,5} next cycle -> rdata={0x0, 0x12345678}, busy_vec=0.
- Bypass: we=1, waddr=7, wdata=0xA5A5A5A5, same cycle raddr[1]=7 -> rdata[1]=0xA5A5A5A5 combinationally. Repeat with BYPASS=0 -> old value 0x0, then 0xA5A5A5A5 the next cycle.
- Scoreboard: issue_rd=3, then raddr[0]=3 -> rbusy[0]=1 for the following cycles; on writeback to x3 the same-cycle rbusy[0]=0 (BYPASS=1); afterwards busy_vec[3]=0.
- Priority: busy[9]=1, same cycle issue_rd=9 and we/waddr=9 -> busy_vec[9]=1 after the edge; regs[9] holds the written data.
- Async reset mid-operation: busy[4]=1, regs[4]=0x55; pull rst_n low between edges -> rdata, busy_vec and rbusy go to 0 immediately, without waiting for a clock edge.
- Parameter sweep: NREGS=16, NRD=3, XLEN=64; randomised issue/writeback against a reference model -> all ports match every cycle.
